p_fadd_sub_hs: RTL and testbench
================================

# p_fadd_sub_hs

Parametrised, three-stage pipelined IEEE-754 floating-point adder/subtractor with a valid/ready handshake on both sides and an opaque tag carried alongside each operation. It generalises the fixed single-precision add/sub pipeline in three ways: any exponent/mantissa width, round-to-nearest-even with full special-value handling, and per-stage backpressure. It sits between an operand issue queue (upstream) and a result writeback arbiter (downstream), which may stall.

## Interface
Parameters:
- EXP_W, 8, exponent field width (≥3).
- MAN_W, 23, stored mantissa field width (≥2); total word width W = 1+EXP_W+MAN_W.
- TAG_W, 4, width of the pass-through tag.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  asynchronous, active-low reset; clears all stage valid bits.
- in_valid  in  1  upstream operation present.
- in_ready  out  1  block accepts the operation this cycle.
- in1, in2  in  W  IEEE operands.
- op  in  1  1 = in1−in2, 0 = in1+in2.
- in_tag  in  TAG_W  opaque tag.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- out  out  W  rounded result.
- out_tag  out  TAG_W  tag of the result.
- overflow, underflow, invalid  out  1 each  exception flags qualified by out_valid.

## Operation
- Stages: A (unpack, swap so |A|≥|B|, align with G/R/S sticky), C (add/subtract magnitudes, MAN_W+5 bits), N (leading-zero normalise, RNE round, pack, flags). Each stage has a register with its own valid bit; tag and flags travel with the data.
- Stage k loads when !v_k or stage k+1 loads this cycle. Output stage loads when !out_valid or out_ready. in_ready = stage A loads. Bubbles collapse.
- Effective sign/op: B's sign is inverted when op=1.
- Subnormal inputs: exponent 0 → implied bit 0, effective exponent 1.
- Rounding: RNE only. Mantissa carry-out after rounding increments the exponent.
- Exact zero from cancellation → +0. (−0)+(−0) → −0.
- NaN on either input → canonical qNaN (sign 0, exp all ones, mantissa MSB 1, rest 0). invalid = 0 unless the NaN arises from inf−inf, which sets invalid = 1.
- Inf ± finite → that inf, no flags.
- Finite overflow → ±inf with overflow = 1.
- underflow = 1 iff the packed result has exponent field 0, is nonzero, and the rounding was inexact (G|R|S ≠ 0).
- Order is strictly preserved; no result is ever dropped or duplicated.

## Timing
- Latency: an operation accepted at rising edge n is presented with out_valid = 1 after edge n+2, provided there is no stall.
- Throughput: 1 op/cycle while out_ready = 1.
- Capacity: 3 operations in flight. With out_ready held at 0, in_ready falls after the pipe holds 3 ops.
- in_ready is combinational from out_ready and the valid bits. It has no combinational path from in_valid.
- While out_valid = 1 and out_ready = 0, out, out_tag and the flags hold stable.
- A simultaneous accept at the output and load at the input in one cycle is legal and keeps the pipe full.
- Reset values, when rst is low: all valid bits 0, so out_valid = 0 and in_ready = 1 (once reset is released). out, out_tag and the flags are 0.
- Reset mid-operation: asserting rst discards all in-flight ops immediately and asynchronously. The first accept is allowed at the first rising edge after rst returns high.

## Test plan
- Default params, back-to-back ops with out_ready = 1:
  - 0x3F800000+0x3F800000 → 0x40000000
  - 0x3F800000−0x3F800000 → 0x00000000
  - 0x3FC00000−0x40000000 → 0xBF000000
  - Each result appears 2 edges after its accept, with tags 1, 2, 3 in order and no flags.
- Specials:
  - 0x7F7FFFFF+0x7F7FFFFF → 0x7F800000, overflow = 1.
  - 0x7F800000−0x7F800000 → 0x7FC00000, invalid = 1.
  - 0x7FC00001+0x3F800000 → 0x7FC00000, invalid = 0.
- Subnormal and rounding:
  - 0x00000001+0x00000001 → 0x00000002, no flags.
  - 0x3F800000+0x33800000 → 0x3F800000 (tie rounds to even).
  - 0x3F800001+0x33800000 → 0x3F800002.
  - 0x00800001−0x00800000 → 0x00000001, underflow = 0 (exact).
- Backpressure: hold in_valid = 1 with 5 ops while out_ready = 0 for 6 cycles.
  - in_ready drops after 3 accepts.
  - out stays stable throughout.
  - After out_ready rises, all 5 ops emerge in order at 1 per cycle with no loss.
- Reset mid-stream: assert rst with 3 ops in flight.
  - out_valid = 0 immediately.
  - After release, a new op 0x40400000+0x3F800000 → 0x40800000, with none of the old ops reappearing.
- Half precision (EXP_W=5, MAN_W=10): 0x3C00+0x3C00 → 0x4000; 0x7BFF+0x7BFF → 0x7C00 with overflow = 1.

Source files
------------

// File: rtl/p_fadd_sub_hs.sv
// Three-stage pipelined IEEE-754 adder/subtractor (any EXP_W/MAN_W) with
// valid/ready backpressure on every stage, RNE rounding and full special-value handling.
module p_fadd_sub_hs #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] in1,
    input  logic [EXP_W+MAN_W:0] in2,
    input  logic                 op,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] out,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 overflow,
    output logic                 underflow,
    output logic                 invalid
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int XW = MAN_W + 4;
    localparam int SW = MAN_W + 5;
    localparam int LW = $clog2(XW + 1);
    localparam int NW = ((EXP_W > LW) ? EXP_W : LW) + 2;
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    function automatic logic [XW-1:0] align(input logic [MAN_W:0] m, input logic [EXP_W-1:0] d);
        logic [XW-1:0] ext;
        logic [XW-1:0] lost;
        ext = {m, 3'b000};
        if (int'(d) >= XW) begin
            align = {{(XW-1){1'b0}}, |m};
        end else begin
            lost  = ext & ~({XW{1'b1}} << d);
            align = (ext >> d) | {{(XW-1){1'b0}}, |lost};
        end
    endfunction

    function automatic logic [LW-1:0] lzc(input logic [XW-1:0] v);
        lzc = LW'(XW);
        for (int i = 0; i < XW; i++) begin
            if (v[i]) lzc = LW'(XW - 1 - i);
        end
    endfunction

    function automatic logic rne_up(input logic [XW-1:0] m);
        rne_up = m[2] & (m[1] | m[0] | m[3]);
    endfunction

    // Returns {overflow, packed word}; exponents at or past all-ones saturate to inf.
    function automatic logic [W:0] pack_sat(input logic s, input logic [NW-1:0] e,
                                            input logic [MAN_W-1:0] f);
        if (e >= NW'(EXP_ONES)) pack_sat = {1'b1, s, EXP_ONES, {MAN_W{1'b0}}};
        else                    pack_sat = {1'b0, s, e[EXP_W-1:0], f};
    endfunction

    logic load_a, load_c, load_n;
    logic vld_p0, vld_p1;

    assign load_n   = !out_valid || out_ready;
    assign load_c   = !vld_p1 || load_n;
    assign load_a   = !vld_p0 || load_c;
    assign in_ready = load_a;

    // Stage A: unpack, order by magnitude, align the smaller operand with sticky.
    logic             s1, s2, swap, nan_any, inf1, inf2, inf_inf, eff_sub, hid_a, hid_b;
    logic [EXP_W-1:0] e1, e2, ea, eb, ea_eff, eb_eff;
    logic [MAN_W-1:0] f1, f2, fa, fb;
    logic [W-1:0]     spec_val;

    always_comb begin
        s1      = in1[W-1];
        s2      = in2[W-1] ^ op;
        e1      = in1[W-2:MAN_W];
        e2      = in2[W-2:MAN_W];
        f1      = in1[MAN_W-1:0];
        f2      = in2[MAN_W-1:0];
        swap    = in2[W-2:0] > in1[W-2:0];
        inf1    = (e1 == EXP_ONES) && (f1 == '0);
        inf2    = (e2 == EXP_ONES) && (f2 == '0);
        nan_any = ((e1 == EXP_ONES) && (f1 != '0)) || ((e2 == EXP_ONES) && (f2 != '0));
        eff_sub = s1 ^ s2;
        inf_inf = inf1 && inf2 && eff_sub;
        if (nan_any || inf_inf) spec_val = QNAN;
        else if (inf1)          spec_val = {s1, EXP_ONES, {MAN_W{1'b0}}};
        else                    spec_val = {s2, EXP_ONES, {MAN_W{1'b0}}};
        ea     = swap ? e2 : e1;
        eb     = swap ? e1 : e2;
        fa     = swap ? f2 : f1;
        fb     = swap ? f1 : f2;
        hid_a  = (ea != '0);
        hid_b  = (eb != '0);
        ea_eff = hid_a ? ea : EXP_W'(1);
        eb_eff = hid_b ? eb : EXP_W'(1);
    end

    logic             sign_p0, sub_p0, spec_p0, inv_p0;
    logic [EXP_W-1:0] exp_p0;
    logic [MAN_W:0]   ma_p0;
    logic [XW-1:0]    mb_p0;
    logic [W-1:0]     specv_p0;
    logic [TAG_W-1:0] tag_p0;

    always_ff @(posedge clk) begin
        if (load_a && in_valid) begin
            sign_p0  <= swap ? s2 : s1;
            exp_p0   <= ea_eff;
            ma_p0    <= {hid_a, fa};
            mb_p0    <= align({hid_b, fb}, ea_eff - eb_eff);
            sub_p0   <= eff_sub;
            spec_p0  <= nan_any || inf1 || inf2;
            specv_p0 <= spec_val;
            inv_p0   <= inf_inf;
            tag_p0   <= in_tag;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            if (load_a) vld_p0 <= in_valid;
            if (load_c) vld_p1 <= vld_p0;
        end
    end

    // Stage C: magnitude add/subtract; |A| >= |B| keeps the difference non-negative.
    logic             sign_p1, sub_p1, spec_p1, inv_p1;
    logic [EXP_W-1:0] exp_p1;
    logic [SW-1:0]    sum_p1;
    logic [W-1:0]     specv_p1;
    logic [TAG_W-1:0] tag_p1;

    always_ff @(posedge clk) begin
        if (load_c && vld_p0) begin
            sum_p1   <= sub_p0 ? ({1'b0, ma_p0, 3'b000} - {1'b0, mb_p0})
                               : ({1'b0, ma_p0, 3'b000} + {1'b0, mb_p0});
            sign_p1  <= sign_p0;
            exp_p1   <= exp_p0;
            sub_p1   <= sub_p0;
            spec_p1  <= spec_p0;
            specv_p1 <= specv_p0;
            inv_p1   <= inv_p0;
            tag_p1   <= tag_p0;
        end
    end

    // Stage N: normalise (left shift capped so the exponent never drops below 1), round, pack.
    logic [NW-1:0]    e_w, ne, ef, shamt;
    logic [LW-1:0]    lz;
    logic [XW-1:0]    nm;
    logic [MAN_W+1:0] mr;
    logic [MAN_W-1:0] fr;
    logic [W:0]       pk;
    logic [W-1:0]     res_n;
    logic             inexact, ovf_n, unf_n, inv_n;

    always_comb begin
        e_w   = NW'(exp_p1);
        lz    = lzc(sum_p1[XW-1:0]);
        shamt = '0;
        if (sum_p1[SW-1]) begin
            nm = {sum_p1[SW-1:2], sum_p1[1] | sum_p1[0]};
            ne = e_w + NW'(1);
        end else begin
            shamt = (NW'(lz) < e_w - NW'(1)) ? NW'(lz) : e_w - NW'(1);
            nm    = sum_p1[XW-1:0] << shamt;
            ne    = e_w - shamt;
        end
        mr = {1'b0, nm[XW-1:3]} + {{(MAN_W+1){1'b0}}, rne_up(nm)};
        if (mr[MAN_W+1]) begin
            ef = ne + NW'(1);
            fr = mr[MAN_W:1];
        end else begin
            ef = mr[MAN_W] ? ne : '0;
            fr = mr[MAN_W-1:0];
        end
        inexact = |nm[2:0];
        pk      = pack_sat(sign_p1, ef, fr);
        res_n   = pk[W-1:0];
        ovf_n   = pk[W];
        unf_n   = 1'b0;
        inv_n   = 1'b0;
        if (spec_p1) begin
            res_n = specv_p1;
            ovf_n = 1'b0;
            inv_n = inv_p1;
        end else if (sum_p1 == '0) begin
            res_n = {sign_p1 & ~sub_p1, {(W-1){1'b0}}};
            ovf_n = 1'b0;
        end else begin
            unf_n = (ef == '0) && (fr != '0) && inexact;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out       <= '0;
            out_tag   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            invalid   <= 1'b0;
        end else if (load_n) begin
            out_valid <= vld_p1;
            if (vld_p1) begin
                out       <= res_n;
                out_tag   <= tag_p1;
                overflow  <= ovf_n;
                underflow <= unf_n;
                invalid   <= inv_n;
            end
        end
    end
endmodule

// File: tb/tb_p_fadd_sub_hs.sv
// Scoreboard bench for p_fadd_sub_hs: single-precision instance plus a half-precision instance.
`timescale 1ns/1ps
module tb_p_fadd_sub_hs;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, op, out_valid, out_ready, overflow, underflow, invalid;
    logic [31:0] in1, in2, out;
    logic [3:0]  in_tag, out_tag;
    logic        h_in_valid, h_in_ready, h_op, h_out_valid, h_out_ready;
    logic        h_overflow, h_underflow, h_invalid;
    logic [15:0] h_in1, h_in2, h_out;
    logic [3:0]  h_in_tag, h_out_tag;

    p_fadd_sub_hs dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .op(op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .out_tag(out_tag),
        .overflow(overflow), .underflow(underflow), .invalid(invalid)
    );

    p_fadd_sub_hs #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) dut_h (
        .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .in1(h_in1), .in2(h_in2), .op(h_op), .in_tag(h_in_tag),
        .out_valid(h_out_valid), .out_ready(h_out_ready), .out(h_out), .out_tag(h_out_tag),
        .overflow(h_overflow), .underflow(h_underflow), .invalid(h_invalid)
    );

    typedef struct {
        logic [31:0] res;
        logic [3:0]  tag;
        logic [2:0]  flg;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t sb_h[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   acc_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input bit half, input logic [31:0] a, input logic [31:0] b,
                         input logic o, input logic [3:0] tag, input logic [31:0] res,
                         input logic [2:0] flg, input bit lat);
        exp_t e;
        int   waited;
        logic rdy;
        waited = 0;
        rdy    = 1'b0;
        if (half) begin
            h_in_valid = 1'b1; h_in1 = a[15:0]; h_in2 = b[15:0]; h_op = o; h_in_tag = tag;
        end else begin
            in_valid = 1'b1; in1 = a; in2 = b; op = o; in_tag = tag;
        end
        forever begin
            @(negedge clk);
            rdy = half ? h_in_ready : in_ready;
            if (rdy) break;
            waited++;
            if (waited > 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL accept_timeout: tag %0d not accepted, required accept within 200 cycles", tag);
                break;
            end
            @(posedge clk);
            #1;
        end
        if (rdy) begin
            acc_cnt++;
            e.res = res;
            e.tag = tag;
            e.flg = flg;
            e.due = lat ? cyc + 3 : -1;
            if (half) sb_h.push_back(e);
            else      sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (half) h_in_valid = 1'b0;
        else      in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || sb_h.size() != 0) && t < 100) begin
            @(posedge clk);
            t++;
        end
        chk("drain_main", 32'(sb.size()), 32'd0);
        chk("drain_half", 32'(sb_h.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin : mon_main
        logic        hold_vld;
        logic [31:0] hold_out;
        logic [3:0]  hold_tag;
        logic [2:0]  hold_flg;
        exp_t        e;
        hold_vld = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && out_valid) begin
                if (!out_ready) begin
                    if (hold_vld) begin
                        chk("stall_out", out, hold_out);
                        chk("stall_tag", 32'(out_tag), 32'(hold_tag));
                        chk("stall_flags", 32'({overflow, underflow, invalid}), 32'(hold_flg));
                    end
                    hold_vld = 1'b1;
                    hold_out = out;
                    hold_tag = out_tag;
                    hold_flg = {overflow, underflow, invalid};
                end else begin
                    hold_vld = 1'b0;
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_out: actual %h tag %0d, required no output", out, out_tag);
                    end else begin
                        e = sb.pop_front();
                        chk("result", out, e.res);
                        chk("tag", 32'(out_tag), 32'(e.tag));
                        chk("flags", 32'({overflow, underflow, invalid}), 32'(e.flg));
                        if (e.due >= 0) chk("latency", 32'(cyc), 32'(e.due));
                    end
                end
            end else begin
                hold_vld = 1'b0;
            end
        end
    end

    initial begin : mon_half
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && h_out_valid && h_out_ready) begin
                if (sb_h.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_half_out: actual %h, required no output", h_out);
                end else begin
                    e = sb_h.pop_front();
                    chk("half_result", 32'(h_out), e.res);
                    chk("half_tag", 32'(h_out_tag), 32'(e.tag));
                    chk("half_flags", 32'({h_overflow, h_underflow, h_invalid}), 32'(e.flg));
                    if (e.due >= 0) chk("half_latency", 32'(cyc), 32'(e.due));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000 ns");
        $fatal(1);
    end

    initial begin : stim
        int n_out;
        rst = 1'b0;
        in_valid = 1'b0; in1 = '0; in2 = '0; op = 1'b0; in_tag = '0; out_ready = 1'b1;
        h_in_valid = 1'b0; h_in1 = '0; h_in2 = '0; h_op = 1'b0; h_in_tag = '0; h_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out", out, 32'd0);
        chk("reset_out_tag", 32'(out_tag), 32'd0);
        chk("reset_flags", 32'({overflow, underflow, invalid}), 32'd0);
        chk("reset_half_out_valid", 32'(h_out_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Back-to-back with fixed latency, specials, subnormals and rounding.
        issue(0, 32'h3F800000, 32'h3F800000, 1'b0, 4'd1, 32'h40000000, 3'b000, 1);
        issue(0, 32'h3F800000, 32'h3F800000, 1'b1, 4'd2, 32'h00000000, 3'b000, 1);
        issue(0, 32'h3FC00000, 32'h40000000, 1'b1, 4'd3, 32'hBF000000, 3'b000, 1);
        issue(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 4'd4, 32'h7F800000, 3'b100, 1);
        issue(0, 32'h7F800000, 32'h7F800000, 1'b1, 4'd5, 32'h7FC00000, 3'b001, 1);
        issue(0, 32'h7FC00001, 32'h3F800000, 1'b0, 4'd6, 32'h7FC00000, 3'b000, 1);
        issue(0, 32'h00000001, 32'h00000001, 1'b0, 4'd7, 32'h00000002, 3'b000, 1);
        issue(0, 32'h3F800000, 32'h33800000, 1'b0, 4'd8, 32'h3F800000, 3'b000, 1);
        issue(0, 32'h3F800001, 32'h33800000, 1'b0, 4'd9, 32'h3F800002, 3'b000, 1);
        issue(0, 32'h00800001, 32'h00800000, 1'b1, 4'd10, 32'h00000001, 3'b000, 1);
        issue(0, 32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 4'd11, 32'hFF800000, 3'b100, 1);
        issue(0, 32'hFF800000, 32'h3F800000, 1'b0, 4'd12, 32'hFF800000, 3'b000, 1);
        issue(0, 32'h80000000, 32'h80000000, 1'b0, 4'd13, 32'h80000000, 3'b000, 1);
        issue(0, 32'h3FFFFFFF, 32'h33800000, 1'b0, 4'd14, 32'h40000000, 3'b000, 1);
        wait_drain();

        // Backpressure: five ops against a stalled output.
        out_ready = 1'b0;
        acc_cnt = 0;
        fork
            begin
                issue(0, 32'h3F800000, 32'h3F800000, 1'b0, 4'd1, 32'h40000000, 3'b000, 0);
                issue(0, 32'h40000000, 32'h3F800000, 1'b0, 4'd2, 32'h40400000, 3'b000, 0);
                issue(0, 32'h40400000, 32'h3F800000, 1'b0, 4'd3, 32'h40800000, 3'b000, 0);
                issue(0, 32'h40800000, 32'h3F800000, 1'b0, 4'd4, 32'h40A00000, 3'b000, 0);
                issue(0, 32'h40A00000, 32'h3F800000, 1'b1, 4'd5, 32'h40800000, 3'b000, 0);
            end
            begin
                repeat (4) @(posedge clk);
                @(negedge clk);
                chk("bp_in_ready", 32'(in_ready), 32'd0);
                chk("bp_accepts", 32'(acc_cnt), 32'd3);
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b1;
                n_out = 0;
                repeat (5) begin
                    @(negedge clk);
                    if (out_valid) n_out++;
                end
                chk("bp_rate", 32'(n_out), 32'd5);
            end
        join
        wait_drain();

        // Reset with three ops in flight.
        out_ready = 1'b0;
        issue(0, 32'h3F800000, 32'h3F800000, 1'b0, 4'd6, 32'h40000000, 3'b000, 0);
        issue(0, 32'h40000000, 32'h3F800000, 1'b0, 4'd7, 32'h40400000, 3'b000, 0);
        issue(0, 32'h40400000, 32'h3F800000, 1'b0, 4'd8, 32'h40800000, 3'b000, 0);
        chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out", out, 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        out_ready = 1'b1;
        issue(0, 32'h40400000, 32'h3F800000, 1'b0, 4'd9, 32'h40800000, 3'b000, 1);
        wait_drain();

        // Half precision.
        issue(1, 32'h3C00, 32'h3C00, 1'b0, 4'd1, 32'h4000, 3'b000, 1);
        issue(1, 32'h7BFF, 32'h7BFF, 1'b0, 4'd2, 32'h7C00, 3'b100, 1);
        issue(1, 32'h3C00, 32'h1000, 1'b0, 4'd3, 32'h3C00, 3'b000, 1);
        issue(1, 32'h3C01, 32'h1000, 1'b0, 4'd4, 32'h3C02, 3'b000, 1);
        wait_drain();

        repeat (5) @(posedge clk);
        chk("final_queue_main", 32'(sb.size()), 32'd0);
        chk("final_queue_half", 32'(sb_h.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
